traffic_light_scheduler: RTL and testbench

TRAFFIC_LIGHT_SCHEDULER -- requirements
Module: traffic_light_scheduler

---
 rtl/traffic_light_scheduler.sv | 178 +++++++++++++++++
 tb/tb_traffic_light_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_scheduler.sv
// Traffic light scheduler for a main/side road intersection.
// Sequences MG -> MY -> AR_MS -> SG -> SY -> AR_SM -> MG on backcounter
// expiry, holds main green until a side request is pending, and supports
// a blinking-yellow night mode. All outputs are registered.
module traffic_light_scheduler #(
    parameter int unsigned T_MAIN_GREEN  = 30,
    parameter int unsigned T_MAIN_YELLOW = 3,
    parameter int unsigned T_SIDE_GREEN  = 20,
    parameter int unsigned T_SIDE_YELLOW = 3,
    parameter int unsigned T_ALL_RED     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic       cnt_timeout,
    input  logic       side_req,
    input  logic       night,
    output logic       cnt_load,
    output logic [5:0] cnt_init,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase
);

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned LIGHT_W = 3;

    localparam logic [LIGHT_W-1:0] L_RED = 3'b100;
    localparam logic [LIGHT_W-1:0] L_YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] L_GRN = 3'b001;
    localparam logic [LIGHT_W-1:0] L_OFF = 3'b000;

    typedef enum logic [2:0] {
        ST_MG    = 3'd0,
        ST_MY    = 3'd1,
        ST_AR_MS = 3'd2,
        ST_SG    = 3'd3,
        ST_SY    = 3'd4,
        ST_AR_SM = 3'd5,
        ST_NIGHT = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               boot_q, boot_d;
    logic               pend_q, pend_d;
    logic               blink_q, blink_d;
    logic               load_q, load_d;
    logic [CNT_W-1:0]   init_q, init_d;
    logic [LIGHT_W-1:0] main_q, main_d;
    logic [LIGHT_W-1:0] side_q, side_d;
    logic               timeout_ev;
    logic               pend_now;

    // Dwell time, in seconds, loaded on entry to a timed state.
    function automatic logic [CNT_W-1:0] state_dur(input state_e s);
        logic [CNT_W-1:0] d;
        case (s)
            ST_MG:   d = CNT_W'(T_MAIN_GREEN);
            ST_MY:   d = CNT_W'(T_MAIN_YELLOW);
            ST_SG:   d = CNT_W'(T_SIDE_GREEN);
            ST_SY:   d = CNT_W'(T_SIDE_YELLOW);
            default: d = CNT_W'(T_ALL_RED);
        endcase
        return d;
    endfunction

    // Expiry only counts when no load is in flight and outside night mode.
    assign timeout_ev = cnt_timeout && !load_q && !boot_q && (state_q != ST_NIGHT);
    assign pend_now   = pend_q || side_req;

    // Next-state, counter load, request latch and blink computation.
    always_comb begin
        state_d = state_q;
        boot_d  = 1'b0;
        pend_d  = pend_now;
        blink_d = blink_q;
        load_d  = 1'b0;
        init_d  = init_q;

        if (boot_q) begin
            // First cycle out of reset: arm the all-red clearance in AR_SM.
            load_d = 1'b1;
            init_d = CNT_W'(T_ALL_RED);
        end else if (state_q == ST_NIGHT) begin
            if (pulse) begin
                if (!night) begin
                    state_d = ST_AR_SM;
                    load_d  = 1'b1;
                    init_d  = CNT_W'(T_ALL_RED);
                end else begin
                    blink_d = !blink_q;
                end
            end
        end else if (timeout_ev) begin
            if (night) begin
                state_d = ST_NIGHT;
                blink_d = 1'b1;
            end else begin
                case (state_q)
                    ST_MG:    state_d = pend_now ? ST_MY : ST_MG;
                    ST_MY:    state_d = ST_AR_MS;
                    ST_AR_MS: state_d = ST_SG;
                    ST_SG:    state_d = ST_SY;
                    ST_SY:    state_d = ST_AR_SM;
                    default:  state_d = ST_MG;
                endcase
                load_d = 1'b1;
                init_d = state_dur(state_d);
                // Serving the side road consumes the pending request.
                if (state_d == ST_SG) begin
                    pend_d = 1'b0;
                end
            end
        end
    end

    // Light pattern follows the next state so lights and phase update together.
    always_comb begin
        main_d = L_RED;
        side_d = L_RED;
        case (state_d)
            ST_MG: begin
                main_d = L_GRN;
                side_d = L_RED;
            end
            ST_MY: begin
                main_d = L_YEL;
                side_d = L_RED;
            end
            ST_SG: begin
                main_d = L_RED;
                side_d = L_GRN;
            end
            ST_SY: begin
                main_d = L_RED;
                side_d = L_YEL;
            end
            ST_NIGHT: begin
                main_d = blink_d ? L_YEL : L_OFF;
                side_d = blink_d ? L_YEL : L_OFF;
            end
            default: begin
                main_d = L_RED;
                side_d = L_RED;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_AR_SM;
            boot_q  <= 1'b1;
            pend_q  <= 1'b0;
            blink_q <= 1'b0;
            load_q  <= 1'b0;
            init_q  <= '0;
            main_q  <= L_RED;
            side_q  <= L_RED;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            pend_q  <= pend_d;
            blink_q <= blink_d;
            load_q  <= load_d;
            init_q  <= init_d;
            main_q  <= main_d;
            side_q  <= side_d;
        end
    end

    assign cnt_load   = load_q;
    assign cnt_init   = init_q;
    assign main_light = main_q;
    assign side_light = side_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_scheduler.sv
// Testbench for traffic_light_scheduler: directed scenarios plus randomized
// traffic checked cycle by cycle against a table-driven reference model.
module tb_traffic_light_scheduler;

    localparam int unsigned TMG = 30;
    localparam int unsigned TMY = 3;
    localparam int unsigned TSG = 20;
    localparam int unsigned TSY = 3;
    localparam int unsigned TAR = 2;

    logic       clk = 1'b0;
    logic       rst, pulse, cnt_timeout, side_req, night;
    logic       cnt_load;
    logic [5:0] cnt_init;
    logic [2:0] main_light, side_light, phase;

    int n_checks = 0;
    int n_errors = 0;

    traffic_light_scheduler #(
        .T_MAIN_GREEN (TMG),
        .T_MAIN_YELLOW(TMY),
        .T_SIDE_GREEN (TSG),
        .T_SIDE_YELLOW(TSY),
        .T_ALL_RED    (TAR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse      (pulse),
        .cnt_timeout(cnt_timeout),
        .side_req   (side_req),
        .night      (night),
        .cnt_load   (cnt_load),
        .cnt_init   (cnt_init),
        .main_light (main_light),
        .side_light (side_light),
        .phase      (phase)
    );

    always #5 clk = !clk;

    // Reference model: phases 0..5 form a ring, 6 is night.
    int dur_tbl  [6] = '{TMG, TMY, TAR, TSG, TSY, TAR};
    int main_tbl [6] = '{1, 2, 4, 4, 4, 4};
    int side_tbl [6] = '{4, 4, 4, 1, 2, 4};
    int m_phase, m_init, m_main, m_side;
    bit m_load, m_pend, m_blink, m_boot;

    task automatic model_step();
        bit  was_load;
        bit  p;
        was_load = m_load;
        m_load   = 1'b0;
        p        = m_pend | side_req;
        if (rst) begin
            m_phase = 5; m_init = 0; m_pend = 1'b0; m_blink = 1'b0; m_boot = 1'b1;
            p = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_load = 1'b1; m_init = TAR;
        end else if (m_phase == 6) begin
            if (pulse && !night) begin
                m_phase = 5; m_load = 1'b1; m_init = TAR;
            end else if (pulse) begin
                m_blink = !m_blink;
            end
        end else if (cnt_timeout && !was_load) begin
            if (night) begin
                m_phase = 6; m_blink = 1'b1;
            end else begin
                if (!(m_phase == 0 && !p)) m_phase = (m_phase + 1) % 6;
                m_load = 1'b1;
                m_init = dur_tbl[m_phase];
                if (m_phase == 3) p = 1'b0;
            end
        end
        m_pend = p;
        if (m_phase == 6) begin
            m_main = m_blink ? 2 : 0;
            m_side = m_main;
        end else begin
            m_main = main_tbl[m_phase];
            m_side = side_tbl[m_phase];
        end
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given inputs; DUT compared against the model.
    task automatic step(input bit r, input bit to, input bit pl, input bit sr, input bit nt);
        rst = r; cnt_timeout = to; pulse = pl; side_req = sr; night = nt;
        @(posedge clk);
        model_step();
        #1;
        check_eq("model_phase", int'(phase), m_phase);
        check_eq("model_main",  int'(main_light), m_main);
        check_eq("model_side",  int'(side_light), m_side);
        check_eq("model_load",  int'(cnt_load), int'(m_load));
        check_eq("model_init",  int'(cnt_init), m_init);
    endtask

    task automatic expect_out(input string tag, input int ph, input int mn, input int sd,
                              input int ld, input int in);
        check_eq({tag, "_phase"}, int'(phase), ph);
        check_eq({tag, "_main"},  int'(main_light), mn);
        check_eq({tag, "_side"},  int'(side_light), sd);
        check_eq({tag, "_load"},  int'(cnt_load), ld);
        check_eq({tag, "_init"},  int'(cnt_init), in);
    endtask

    int seq_phase [6] = '{2, 3, 4, 5, 0, 1};
    int seq_init  [6] = '{TAR, TSG, TSY, TAR, TMG, TMY};
    int seq_main  [6] = '{4, 4, 4, 4, 1, 2};
    int seq_side  [6] = '{4, 1, 2, 4, 4, 4};
    int night_lt  [3] = '{0, 2, 0};

    initial begin
        bit nt_r;
        bit rs_r;
        rst = 1'b1; pulse = 1'b0; cnt_timeout = 1'b0; side_req = 1'b0; night = 1'b0;
        m_phase = 5; m_init = 0; m_main = 4; m_side = 4;
        m_load = 1'b0; m_pend = 1'b0; m_blink = 1'b0; m_boot = 1'b1;

        // Reset values and release
        repeat (3) step(1, 1, 1, 1, 0);
        expect_out("reset", 5, 4, 4, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("boot", 5, 4, 4, 1, TAR);
        step(0, 1, 0, 0, 0);
        expect_out("boot_ignore_to", 5, 4, 4, 0, TAR);

        // First timeout enters MG
        step(0, 1, 0, 0, 0);
        expect_out("enter_mg", 0, 1, 4, 1, TMG);
        step(0, 0, 0, 0, 0);
        check_eq("init_hold", int'(cnt_init), TMG);

        // MG re-load without request, then request with timeout
        step(0, 1, 0, 0, 0);
        expect_out("mg_reload", 0, 1, 4, 1, TMG);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        expect_out("mg_to_my", 1, 2, 4, 1, TMY);

        // Timeout during the load cycle is ignored
        step(0, 1, 0, 0, 0);
        expect_out("to_in_load", 1, 2, 4, 0, TMY);

        // Full ring with side_req held
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 1, 0);
            expect_out($sformatf("ring%0d", i), seq_phase[i], seq_main[i], seq_side[i], 1, seq_init[i]);
            step(0, 0, 0, 1, 0);
        end

        // Advance to SG, then enter night mode
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        check_eq("at_sg", int'(phase), 3);
        step(0, 1, 0, 0, 1);
        expect_out("night_in", 6, 2, 2, 0, TSG);
        step(0, 1, 0, 0, 1);
        check_eq("night_ignore_to", int'(phase), 6);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 1);
            check_eq($sformatf("blink%0d_main", i), int'(main_light), night_lt[i]);
            check_eq($sformatf("blink%0d_side", i), int'(side_light), night_lt[i]);
        end
        step(0, 0, 0, 0, 0);
        check_eq("night_hold", int'(phase), 6);
        step(0, 0, 1, 0, 0);
        expect_out("night_out", 5, 4, 4, 1, TAR);

        // Reach SY and reset there
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 1, 0, 1, 0);
        end
        check_eq("at_sy", int'(phase), 4);
        step(1, 1, 1, 1, 1);
        expect_out("reset_sy", 5, 4, 4, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("reboot", 5, 4, 4, 1, TAR);

        // Randomized traffic
        nt_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) nt_r = !nt_r;
            rs_r = ($urandom_range(0, 299) == 0);
            step(rs_r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, nt_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
